// File: rtl/ibuffer_mp_pkg.sv
// Shared defaults, sizing helpers and return-entry layout for ibuffer_mp.
// A return entry is packed as {last, err, data[DATA_W-1:0]}.
package ibuffer_mp_pkg;

    localparam int DEF_NUM_PORTS  = 2;
    localparam int DEF_NUM_BANKS  = 24;
    localparam int DEF_BANK_DEPTH = 1024;
    localparam int DEF_DATA_W     = 128;
    localparam int DEF_RET_DEPTH  = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    function automatic int max1(input int value);
        return (value < 1) ? 1 : value;
    endfunction

    function automatic int ret_w(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/ibuffer_mp_bank_arb.sv
// NUM_PORTS-way round-robin arbiter with one-hot grant; pointer moves past the grantee.
module ibuffer_mp_bank_arb
    import ibuffer_mp_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] grant
);

    localparam int PW = max1(clog2(NUM_PORTS));

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;
    logic          found;

    // Scan ports starting at the pointer; the first requester wins.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        ptr_next = ptr_reg;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!found && req[p] && (p == ((int'(ptr_reg) + i) % NUM_PORTS))) begin
                    found    = 1'b1;
                    grant[p] = 1'b1;
                    ptr_next = (p == NUM_PORTS - 1) ? '0 : PW'(p + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (found) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/ibuffer_mp_sram.sv
// Generic single-port SRAM: byte-enabled writes, registered read with 1-cycle latency.
module ibuffer_mp_sram
    import ibuffer_mp_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 128,
    localparam int AW    = max1(clog2(DEPTH))
) (
    input  logic                  clk,
    input  logic                  cen,
    input  logic                  wen,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (cen) begin
            if (wen) begin
                for (int i = 0; i < DATA_W / 8; i++) begin
                    if (wstrb[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end else begin
                rdata_reg <= mem[addr];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/ibuffer_mp.sv
// Multi-port banked buffer with per-bank round-robin arbitration and credited return queues.
// Optional stall counters are built when IBUF_STALL_CNT_EN is defined.
module ibuffer_mp
    import ibuffer_mp_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int NUM_BANKS  = DEF_NUM_BANKS,
    parameter int BANK_DEPTH = DEF_BANK_DEPTH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RET_DEPTH  = DEF_RET_DEPTH,
    localparam int BW        = clog2(BANK_DEPTH),
    localparam int SW        = max1(clog2(NUM_BANKS)),
    localparam int AW        = SW + BW
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          cen,
    input  logic [NUM_PORTS-1:0]          wen,
    input  logic [NUM_PORTS-1:0]          last,
    input  logic [NUM_PORTS*AW-1:0]       addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
    input  logic [NUM_PORTS*DATA_W/8-1:0] wstrb,
    output logic [NUM_PORTS-1:0]          ready,
    output logic [NUM_PORTS*DATA_W-1:0]   rdata,
    output logic [NUM_PORTS-1:0]          rvalid,
    output logic [NUM_PORTS-1:0]          rlast,
    output logic [NUM_PORTS-1:0]          rerr,
    input  logic [NUM_PORTS-1:0]          rready,
    output logic [NUM_PORTS*32-1:0]       stall_cnt
);

    localparam int CW   = clog2(RET_DEPTH + 1);
    localparam int PTRW = max1(clog2(RET_DEPTH));
    localparam int RW   = ret_w(DATA_W);
    localparam int NBY  = DATA_W / 8;

    logic [SW-1:0]        bank_sel [NUM_PORTS];
    logic [NUM_PORTS-1:0] in_range;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] granted;
    logic [NUM_PORTS-1:0] rd_accept;
    logic [NUM_PORTS-1:0] bank_grant [NUM_BANKS];
    logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] ptr);
        return (ptr == PTRW'(RET_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        granted = '0;
        for (int b = 0; b < NUM_BANKS; b++) granted = granted | bank_grant[b];
    end

    // Out-of-range requests bypass arbitration entirely.
    assign ready     = eligible & (granted | ~in_range);
    assign rd_accept = cen & ready & ~wen;

    genvar gi;

    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [NUM_PORTS-1:0] req;
        logic                 b_wen;
        logic [BW-1:0]        b_addr;
        logic [DATA_W-1:0]    b_wdata;
        logic [NBY-1:0]       b_wstrb;

        always_comb begin
            req = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                req[p] = eligible[p] && in_range[p] && (bank_sel[p] == SW'(gi));
            end
        end

        ibuffer_mp_bank_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (req),
            .grant (bank_grant[gi])
        );

        always_comb begin
            b_wen   = 1'b0;
            b_addr  = '0;
            b_wdata = '0;
            b_wstrb = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bank_grant[gi][p]) begin
                    b_wen   = wen[p];
                    b_addr  = addr[p*AW +: BW];
                    b_wdata = wdata[p*DATA_W +: DATA_W];
                    b_wstrb = wstrb[p*NBY +: NBY];
                end
            end
        end

        ibuffer_mp_sram #(.DEPTH(BANK_DEPTH), .DATA_W(DATA_W)) u_sram (
            .clk   (clk),
            .cen   (|bank_grant[gi]),
            .wen   (b_wen),
            .addr  (b_addr),
            .wdata (b_wdata),
            .wstrb (b_wstrb),
            .rdata (bank_rdata[gi])
        );
    end

    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        logic              pend_reg;
        logic              pend_last_reg;
        logic              pend_err_reg;
        logic [SW-1:0]     pend_bank_reg;
        logic [DATA_W-1:0] pend_data;
        logic [RW-1:0]     fifo_mem [RET_DEPTH];
        logic [RW-1:0]     head;
        logic [PTRW-1:0]   wr_ptr_reg;
        logic [PTRW-1:0]   rd_ptr_reg;
        logic [CW-1:0]     count_reg;
        logic [CW-1:0]     outstanding_reg;
        logic              pop;

        assign bank_sel[gi] = addr[gi*AW+BW +: SW];
        assign in_range[gi] = int'(bank_sel[gi]) < NUM_BANKS;
        assign eligible[gi] = cen[gi] && (wen[gi] || (outstanding_reg < CW'(RET_DEPTH)));
        assign pop          = rvalid[gi] && rready[gi];

        // Second stage of a read: SRAM output is valid now, push it next edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend_reg      <= 1'b0;
                pend_last_reg <= 1'b0;
                pend_err_reg  <= 1'b0;
                pend_bank_reg <= '0;
            end else begin
                pend_reg      <= rd_accept[gi];
                pend_last_reg <= last[gi];
                pend_err_reg  <= !in_range[gi];
                pend_bank_reg <= bank_sel[gi];
            end
        end

        always_comb begin
            pend_data = '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (!pend_err_reg && (pend_bank_reg == SW'(b))) pend_data = bank_rdata[b];
            end
        end

        always_ff @(posedge clk) begin
            if (pend_reg) fifo_mem[wr_ptr_reg] <= {pend_last_reg, pend_err_reg, pend_data};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_reg      <= '0;
                rd_ptr_reg      <= '0;
                count_reg       <= '0;
                outstanding_reg <= '0;
            end else begin
                if (pend_reg) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                if (pop)      rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                case ({pend_reg, pop})
                    2'b10:   count_reg <= count_reg + 1'b1;
                    2'b01:   count_reg <= count_reg - 1'b1;
                    default: count_reg <= count_reg;
                endcase
                case ({rd_accept[gi], pop})
                    2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
                    2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
                    default: outstanding_reg <= outstanding_reg;
                endcase
            end
        end

        assign head                      = fifo_mem[rd_ptr_reg];
        assign rvalid[gi]                = count_reg != '0;
        assign rdata[gi*DATA_W +: DATA_W] = rvalid[gi] ? head[DATA_W-1:0] : '0;
        assign rerr[gi]                  = rvalid[gi] & head[DATA_W];
        assign rlast[gi]                 = rvalid[gi] & head[DATA_W+1];

`ifdef IBUF_STALL_CNT_EN
        logic [31:0] stall_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stall_reg <= '0;
            end else if (cen[gi] && !ready[gi] && (stall_reg != '1)) begin
                stall_reg <= stall_reg + 1'b1;
            end
        end

        assign stall_cnt[gi*32 +: 32] = stall_reg;
`else
        assign stall_cnt[gi*32 +: 32] = '0;
`endif
    end

endmodule

// File: tb/tb_ibuffer_mp.sv
// Directed bench for ibuffer_mp with a per-port response scoreboard and memory model.
module tb_ibuffer_mp;

    localparam int NP = 2;
    localparam int NB = 24;
    localparam int BD = 1024;
    localparam int DW = 128;
    localparam int RD = 4;
    localparam int BW = 10;
    localparam int SW = 5;
    localparam int AW = SW + BW;
    localparam int BY = DW / 8;
`ifdef IBUF_STALL_CNT_EN
    localparam int EXP_STALL = 5;
`else
    localparam int EXP_STALL = 0;
`endif

    logic              clk;
    logic              rst_n;
    logic [NP-1:0]     cen, wen, last, ready, rvalid, rlast, rerr, rready;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  wdata, rdata;
    logic [NP*BY-1:0]  wstrb;
    logic [NP*32-1:0]  stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [DW+1:0] exp_q [NP][$];
    logic [DW-1:0] mem_m [int];

    ibuffer_mp #(
        .NUM_PORTS(NP), .NUM_BANKS(NB), .BANK_DEPTH(BD), .DATA_W(DW), .RET_DEPTH(RD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .wen(wen), .last(last), .addr(addr),
        .wdata(wdata), .wstrb(wstrb), .ready(ready), .rdata(rdata), .rvalid(rvalid),
        .rlast(rlast), .rerr(rerr), .rready(rready), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] mk_addr(input int bank, input int word);
        return {SW'(bank), BW'(word)};
    endfunction

    task automatic set_req(input int p, input logic c, input logic w, input logic l,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BY-1:0] s);
        cen[p] = c;
        wen[p] = w;
        last[p] = l;
        addr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
        wstrb[p*BY +: BY] = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: pop/compare on handshakes, push expectations on accepted reads.
    always @(negedge clk) begin
        logic [AW-1:0] a;
        logic [DW-1:0] cur;
        int bank;
        if (rst_n) begin
            for (int p = 0; p < NP; p++) begin
                if (rvalid[p] && rready[p]) begin
                    n_cmp++;
                    assert (exp_q[p].size() != 0) else begin
                        n_fail++;
                        $error("FAIL unexpected_rvalid_p%0d: observed response expected none", p);
                    end
                    if (exp_q[p].size() != 0)
                        check($sformatf("resp_p%0d", p), {rlast[p], rerr[p], rdata[p*DW +: DW]},
                              exp_q[p].pop_front());
                end
                if (cen[p] && ready[p]) begin
                    a = addr[p*AW +: AW];
                    bank = int'(a[AW-1:BW]);
                    if (wen[p]) begin
                        if (bank < NB) begin
                            cur = mem_m.exists(int'(a)) ? mem_m[int'(a)] : '0;
                            for (int b = 0; b < BY; b++)
                                if (wstrb[p*BY + b]) cur[b*8 +: 8] = wdata[p*DW + b*8 +: 8];
                            mem_m[int'(a)] = cur;
                        end
                    end else if (bank >= NB) begin
                        exp_q[p].push_back({last[p], 1'b1, {DW{1'b0}}});
                    end else begin
                        cur = mem_m.exists(int'(a)) ? mem_m[int'(a)] : '0;
                        exp_q[p].push_back({last[p], 1'b0, cur});
                    end
                end
            end
        end
    end

    initial begin
        int k;
        rst_n = 1'b0; cen = '0; wen = '0; last = '0; addr = '0;
        wdata = '0; wstrb = '0; rready = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rlast_rerr", {rlast, rerr}, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", ready, 0);

        // Write then read back, with latency check.
        set_req(0, 1, 1, 0, mk_addr(0, 16), {16{8'hA5}}, '1);
        #1; check("wr_ready", ready[0], 1);
        tick();
        set_req(0, 1, 0, 1, mk_addr(0, 16), '0, '0);
        #1; check("rd_ready", ready[0], 1);
        tick();
        cen = '0;
        #1; check("lat_t1_rvalid", rvalid[0], 0);
        tick();
        check("lat_t2_rvalid", rvalid[0], 1);
        check("lat_t2_rlast", rlast[0], 1);
        check("lat_t2_rdata", rdata[DW-1:0], {16{8'hA5}});
        tick();

        // Partial-strobe write merges bytes.
        set_req(0, 1, 1, 0, mk_addr(0, 16), {16{8'h11}}, 16'h00FF);
        tick();
        set_req(0, 1, 0, 0, mk_addr(0, 16), '0, '0);
        tick();
        cen = '0;
        repeat (3) tick();

        // Different banks in parallel at full rate.
        for (int w = 0; w < 8; w++) begin
            set_req(0, 1, 1, 0, mk_addr(3, w), rnd_word(), '1);
            set_req(1, 1, 1, 0, mk_addr(7, w), rnd_word(), '1);
            #1; check($sformatf("par_wr_ready_%0d", w), ready, 2'b11);
            tick();
        end
        for (int w = 0; w < 8; w++) begin
            set_req(0, 1, 0, w[0], mk_addr(3, w), '0, '0);
            set_req(1, 1, 0, !w[0], mk_addr(7, w), '0, '0);
            #1; check($sformatf("par_rd_ready_%0d", w), ready, 2'b11);
            tick();
        end
        cen = '0;
        repeat (4) tick();
        check("par_drained", exp_q[0].size() + exp_q[1].size(), 0);

        // Same-bank conflict alternates grants.
        for (int w = 0; w < 16; w++) begin
            set_req(1, 1, 1, 0, mk_addr(5, w), rnd_word(), '1);
            tick();
        end
        cen = '0;
        for (int i = 0; i < 8; i++) begin
            set_req(0, 1, 0, 0, mk_addr(5, i), '0, '0);
            set_req(1, 1, 0, 1, mk_addr(5, 8 + i), '0, '0);
            #1; check($sformatf("rr_ready_%0d", i), ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        cen = '0;
        repeat (4) tick();

        // Credit exhaustion with rready low, then release.
        rready[1] = 1'b0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(1, 1, 0, k[0], mk_addr(3, k), '0, '0);
            #1; check($sformatf("credit_ready_%0d", i), ready[1], (i < 4));
            if (i < 4) k++;
            tick();
        end
        rready[1] = 1'b1;
        #1; check("credit_pop_same_cycle", ready[1], 0);
        tick();
        set_req(1, 1, 0, 1, mk_addr(3, k), '0, '0);
        #1; check("credit_resume", ready[1], 1);
        tick();
        cen = '0;
        repeat (6) tick();
        check("credit_drained", exp_q[1].size(), 0);

        // Out-of-range bank 30.
        set_req(0, 1, 1, 0, mk_addr(6, 16), rnd_word(), '1);
        tick();
        set_req(0, 1, 0, 1, mk_addr(30, 4), '0, '0);
        #1; check("oor_rd_ready", ready[0], 1);
        tick();
        cen = '0;
        #1; check("oor_t1_rvalid", rvalid[0], 0);
        tick();
        check("oor_t2_rvalid", rvalid[0], 1);
        check("oor_t2_rerr", rerr[0], 1);
        check("oor_t2_rdata", rdata[DW-1:0], 0);
        tick();
        set_req(0, 1, 1, 0, mk_addr(30, 16), {DW{1'b1}}, '1);
        #1; check("oor_wr_ready", ready[0], 1);
        tick();
        set_req(0, 1, 0, 0, mk_addr(6, 16), '0, '0);
        tick();
        set_req(0, 1, 0, 0, mk_addr(0, 16), '0, '0);
        tick();
        set_req(0, 1, 0, 1, mk_addr(30, 16), '0, '0);
        tick();
        cen = '0;
        repeat (4) tick();

        // Reset with two reads in flight.
        set_req(0, 1, 0, 0, mk_addr(3, 0), '0, '0);
        set_req(1, 1, 0, 0, mk_addr(7, 0), '0, '0);
        #1; check("inflight_ready", ready, 2'b11);
        tick();
        cen = '0;
        rst_n = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        tick();
        tick();
        check("inrst_rvalid", rvalid, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("postrst_rvalid_%0d", i), rvalid, 0);
        end
        check("postrst_stall_cnt", stall_cnt, 0);

        // Stall counting: 4 accepted, then 5 blocked cycles.
        rready[1] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_req(1, 1, 0, 0, mk_addr(3, i % 4), '0, '0);
            #1; check($sformatf("stall_ready_%0d", i), ready[1], (i < 4));
            tick();
        end
        cen = '0;
        #1;
        check("stall_cnt_p1", stall_cnt[63:32], EXP_STALL);
        check("stall_cnt_p0", stall_cnt[31:0], 0);
        rready[1] = 1'b1;
        repeat (8) tick();

        check("final_q0_empty", exp_q[0].size(), 0);
        check("final_q1_empty", exp_q[1].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
